noc_to_cpu_deflitizer: RTL and testbench
========================================

NOC_TO_CPU_DEFLITIZER -- requirements
Module: noc_to_cpu_deflitizer

Interface
REQ-001 SHALL have parameter FLIT_DATA_WIDTH, default 32, meaning the flit payload width in bits, with a legal minimum of 16.
REQ-002 SHALL have parameter MAX_DATA_FLITS, default 8, meaning the maximum number of data flits per packet.
REQ-003 SHALL have port clk, input, width 1, meaning the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n, input, width 1, meaning reset, which is asynchronous and active-low.
REQ-005 SHALL have port flit_in, input, width FLIT_DATA_WIDTH+2, meaning the incoming flit: [FLIT_DATA_WIDTH+1:FLIT_DATA_WIDTH] is the type (00 HEAD, 01 BODY, 10 TAIL, 11 HEADTAIL) and the low bits are the payload.
REQ-006 SHALL have port flit_in_valid, input, width 1, meaning the NoC side offers a flit.
REQ-007 SHALL have port flit_in_ready, output, width 1, meaning the block accepts a flit this cycle.
REQ-008 SHALL have port packet_out_valid, output, width 1, meaning a reassembled packet is presented.
REQ-009 SHALL have port packet_out_ready, input, width 1, meaning the CPU side accepts the packet.
REQ-010 SHALL have ports packet_src and packet_dst, output, width 8 each, meaning the header source and destination IDs.
REQ-011 SHALL have port packet_len, output, width $clog2(MAX_DATA_FLITS+1), meaning the number of valid data words.
REQ-012 SHALL have port packet_data, output, width MAX_DATA_FLITS*FLIT_DATA_WIDTH, meaning the data words, with word i at bits [i*W +: W].
REQ-013 SHALL have port error_pulse, output, width 1, meaning a one-cycle protocol-error indication.

Function
REQ-014 A flit SHALL be accepted only on a rising edge where flit_in_valid and flit_in_ready are both 1.
REQ-015 A packet SHALL be accepted only on a rising edge where packet_out_valid and packet_out_ready are both 1.
REQ-016 HEAD/HEADTAIL payload SHALL be decoded as follows: payload[7:0] is src and payload[15:8] is dst; the remaining bits are ignored.
REQ-017 BODY/TAIL payload SHALL each be captured as one data word.
REQ-018 The FSM SHALL have exactly the states IDLE, COLLECT, OUTPUT and DROP.
REQ-019 flit_in_ready SHALL be 1 in IDLE, COLLECT and DROP, and 0 in OUTPUT.
REQ-020 packet_out_valid SHALL be 1 only in OUTPUT.
REQ-021 In IDLE, an accepted HEAD SHALL:
- capture src/dst;
- clear len to 0;
- clear all data words to 0;
- move the FSM to COLLECT.
REQ-022 In IDLE, an accepted HEADTAIL SHALL capture src/dst, set len=0, clear the data, and move the FSM to OUTPUT.
REQ-023 In IDLE, an accepted BODY or TAIL SHALL be discarded, pulse error, and leave the FSM in IDLE.
REQ-024 In COLLECT, an accepted BODY with len<MAX_DATA_FLITS SHALL store the word at index len and increment len.
REQ-025 In COLLECT, an accepted TAIL with len<MAX_DATA_FLITS SHALL store the word at index len, increment len, and move the FSM to OUTPUT.
REQ-026 In COLLECT, an accepted BODY or TAIL with len==MAX_DATA_FLITS (overflow) SHALL pulse error and discard the partial packet.
- BODY: the FSM moves to DROP.
- TAIL: the FSM moves to IDLE.
REQ-027 In COLLECT, an accepted HEAD or HEADTAIL SHALL pulse error, abandon the partial packet, and be processed as in REQ-021 or REQ-022.
REQ-028 In DROP, accepted BODY flits SHALL be discarded, and an accepted TAIL SHALL be discarded with the FSM moving to IDLE.
REQ-029 In DROP, an accepted HEAD or HEADTAIL SHALL be processed as in REQ-021 or REQ-022 without an error pulse.
REQ-030 In OUTPUT, packet_src, packet_dst, packet_len and packet_data SHALL be held stable until packet acceptance, at which point the FSM moves to IDLE.
REQ-031 packet_out_valid SHALL assert on the first rising edge after the completing TAIL or HEADTAIL is accepted (latency 1 cycle).
REQ-032 The minimum packet period SHALL be one flit per cycle plus one OUTPUT cycle when packet_out_ready is held at 1.
REQ-033 error_pulse SHALL be registered and high for exactly one cycle, the cycle after the offending flit is accepted.
REQ-034 Data words at indices >= packet_len SHALL read as 0.
REQ-035 Flits with flit_in_valid=0 SHALL never change state.

Reset
REQ-036 While rst_n=0, the block SHALL force, without waiting for clk:
- state=IDLE;
- flit_in_ready=0;
- packet_out_valid=0;
- packet_src=0, packet_dst=0, packet_len=0, packet_data=0;
- error_pulse=0.
REQ-037 flit_in_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-038 Reset asserted mid-packet or in OUTPUT SHALL discard the packet, and no packet_out_valid SHALL follow the reset.

Verification
REQ-039 The bench SHALL cover the normal packet: HEAD(src=0x12, dst=0x34), BODY 0xA0, BODY 0xA1, TAIL 0xA2 with ready=1 -> one cycle after TAIL, valid=1, src=0x12, dst=0x34, len=3, words 0..2 = A0,A1,A2, words 3..7 = 0, error never asserted.
REQ-040 The bench SHALL cover backpressure: the same packet with packet_out_ready=0 for 5 cycles -> valid and outputs stable for 5 cycles, flit_in_ready=0 throughout, then IDLE the cycle after ready=1.
REQ-041 The bench SHALL cover HEADTAIL(src=0x01, dst=0x02) -> valid next cycle, len=0, packet_data=0.
REQ-042 The bench SHALL cover the orphan-flit cases:
- BODY in IDLE -> error_pulse high for one cycle, no packet.
- HEAD, BODY 0x5, then HEAD(src=0x7) -> one error pulse, then the new packet reassembles with src=0x7.
REQ-043 The bench SHALL cover overflow: HEAD plus 9 BODY plus TAIL -> one error pulse on the 9th BODY, the TAIL returns the FSM to IDLE, no valid; a following HEAD/TAIL packet is delivered correctly.
REQ-044 The bench SHALL cover reset mid-packet: rst_n low after HEAD and 2 BODY -> all outputs 0 immediately, and after release a fresh packet is delivered with len counted from 0.

Source files
------------

// File: rtl/noc_to_cpu_deflitizer.sv
// noc_to_cpu_deflitizer: reassembles HEAD/BODY/TAIL flits into one packet for the CPU side
//   clk, rst_n                  : clock, asynchronous active-low reset
//   flit_in/_valid/_ready       : NoC flit stream, type in the top two bits
//   packet_out_valid/_ready     : reassembled packet handshake
//   packet_src/dst/len/data     : header IDs, data word count, data words (word i at [i*W +: W])
//   error_pulse                 : one-cycle protocol-error indication
module noc_to_cpu_deflitizer #(
  parameter int FLIT_DATA_WIDTH = 32,
  parameter int MAX_DATA_FLITS = 8,
  localparam int LW = $clog2(MAX_DATA_FLITS + 1)
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [FLIT_DATA_WIDTH+1:0]                flit_in,
  input  logic                                      flit_in_valid,
  output logic                                      flit_in_ready,
  output logic                                      packet_out_valid,
  input  logic                                      packet_out_ready,
  output logic [7:0]                                packet_src,
  output logic [7:0]                                packet_dst,
  output logic [LW-1:0]                             packet_len,
  output logic [MAX_DATA_FLITS*FLIT_DATA_WIDTH-1:0] packet_data,
  output logic                                      error_pulse
);
  typedef enum logic [1:0] {IDLE, COLLECT, OUTPUT, DROP} state_t;
  localparam logic [LW-1:0] MAX_LEN = LW'(MAX_DATA_FLITS);
  state_t state_q, state_d;
  logic ready_q, ready_d, valid_q, valid_d, err_q, err_d;
  logic [7:0] src_q, src_d, dst_q, dst_d;
  logic [LW-1:0] len_q, len_d;
  logic [MAX_DATA_FLITS*FLIT_DATA_WIDTH-1:0] data_q, data_d;
  logic [1:0] typ;
  logic [FLIT_DATA_WIDTH-1:0] pay;
  logic is_head;
  assign typ = flit_in[FLIT_DATA_WIDTH+1:FLIT_DATA_WIDTH];
  assign pay = flit_in[FLIT_DATA_WIDTH-1:0];
  // typ[1] marks a packet-ending flit (TAIL or HEADTAIL)
  assign is_head = typ == 2'b00 || typ == 2'b11;
  always_comb begin
    state_d = state_q;
    src_d = src_q;
    dst_d = dst_q;
    len_d = len_q;
    data_d = data_q;
    err_d = 1'b0;
    if (flit_in_valid && ready_q) begin
      if (is_head) begin
        src_d = pay[7:0];
        dst_d = pay[15:8];
        len_d = '0;
        data_d = '0;
        state_d = typ[1] ? OUTPUT : COLLECT;
        err_d = state_q == COLLECT;
      end else if (state_q == IDLE) begin
        err_d = 1'b1;
      end else if (state_q == COLLECT && len_q < MAX_LEN) begin
        data_d[int'(len_q)*FLIT_DATA_WIDTH +: FLIT_DATA_WIDTH] = pay;
        len_d = len_q + LW'(1);
        state_d = typ[1] ? OUTPUT : COLLECT;
      end else begin
        err_d = state_q == COLLECT;
        state_d = typ[1] ? IDLE : DROP;
      end
    end else if (state_q == OUTPUT && packet_out_ready) begin
      state_d = IDLE;
    end
    ready_d = state_d != OUTPUT;
    valid_d = state_d == OUTPUT;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      err_q <= err_d;
      src_q <= src_d;
      dst_q <= dst_d;
      len_q <= len_d;
      data_q <= data_d;
    end
  end
  assign flit_in_ready = ready_q;
  assign packet_out_valid = valid_q;
  assign error_pulse = err_q;
  assign packet_src = src_q;
  assign packet_dst = dst_q;
  assign packet_len = len_q;
  assign packet_data = data_q;
endmodule

// File: tb/tb_noc_to_cpu_deflitizer.sv
// tb_noc_to_cpu_deflitizer: directed self-checking bench for noc_to_cpu_deflitizer
module tb_noc_to_cpu_deflitizer;
  localparam logic [1:0] HD = 2'b00, BD = 2'b01, TL = 2'b10, HT = 2'b11;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [33:0] flit_in = '0;
  logic flit_in_valid = 1'b0;
  logic flit_in_ready;
  logic packet_out_valid;
  logic packet_out_ready = 1'b1;
  logic [7:0] packet_src, packet_dst;
  logic [3:0] packet_len;
  logic [255:0] packet_data;
  logic error_pulse;
  int errs = 0, checks = 0, err_cnt = 0, vld_cnt = 0, e0, v0;
  noc_to_cpu_deflitizer dut (
    .clk(clk), .rst_n(rst_n), .flit_in(flit_in), .flit_in_valid(flit_in_valid),
    .flit_in_ready(flit_in_ready), .packet_out_valid(packet_out_valid),
    .packet_out_ready(packet_out_ready), .packet_src(packet_src), .packet_dst(packet_dst),
    .packet_len(packet_len), .packet_data(packet_data), .error_pulse(error_pulse)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (error_pulse) err_cnt++;
    if (packet_out_valid) vld_cnt++;
  end
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [1:0] t, input logic [31:0] p);
    flit_in = {t, p};
    flit_in_valid = 1'b1;
    tick();
    flit_in_valid = 1'b0;
  endtask
  function automatic logic [255:0] words(input int n, input logic [31:0] base);
    logic [255:0] r = '0;
    for (int i = 0; i < n; i++) r[i*32 +: 32] = base + 32'(i);
    return r;
  endfunction
  task automatic pkt(input string tag, input logic [7:0] s, input logic [7:0] d, input int n, input logic [31:0] base);
    chk({tag, "_valid"}, 256'(packet_out_valid), 256'(1));
    chk({tag, "_src"}, 256'(packet_src), 256'(s));
    chk({tag, "_dst"}, 256'(packet_dst), 256'(d));
    chk({tag, "_len"}, 256'(packet_len), 256'(n));
    chk({tag, "_data"}, packet_data, words(n, base));
  endtask
  initial begin
    #3;
    chk("rst_ready", 256'(flit_in_ready), 256'(0));
    chk("rst_valid", 256'(packet_out_valid), 256'(0));
    chk("rst_err", 256'(error_pulse), 256'(0));
    chk("rst_len", 256'(packet_len), 256'(0));
    #24 rst_n = 1'b1;
    chk("ready_held_low", 256'(flit_in_ready), 256'(0));
    tick();
    chk("ready_after_rst", 256'(flit_in_ready), 256'(1));
    e0 = err_cnt;
    send(HD, 32'h3412); send(BD, 32'hA0); send(BD, 32'hA1); send(TL, 32'hA2);
    pkt("normal", 8'h12, 8'h34, 3, 32'hA0);
    chk("normal_ready_low", 256'(flit_in_ready), 256'(0));
    tick();
    chk("normal_done_valid", 256'(packet_out_valid), 256'(0));
    chk("normal_done_ready", 256'(flit_in_ready), 256'(1));
    chk("normal_no_err", 256'(err_cnt), 256'(e0));
    packet_out_ready = 1'b0;
    send(HD, 32'h3412); send(BD, 32'hA0); send(BD, 32'hA1); send(TL, 32'hA2);
    for (int i = 0; i < 5; i++) begin
      pkt("bp", 8'h12, 8'h34, 3, 32'hA0);
      chk("bp_ready_low", 256'(flit_in_ready), 256'(0));
      tick();
    end
    packet_out_ready = 1'b1;
    tick();
    chk("bp_done_valid", 256'(packet_out_valid), 256'(0));
    chk("bp_done_ready", 256'(flit_in_ready), 256'(1));
    send(HT, 32'h0201);
    pkt("headtail", 8'h01, 8'h02, 0, 32'h0);
    tick();
    chk("headtail_done", 256'(packet_out_valid), 256'(0));
    e0 = err_cnt; v0 = vld_cnt;
    send(BD, 32'h55);
    chk("orphan_err_high", 256'(error_pulse), 256'(1));
    tick();
    chk("orphan_err_low", 256'(error_pulse), 256'(0));
    chk("orphan_err_cnt", 256'(err_cnt), 256'(e0 + 1));
    chk("orphan_no_pkt", 256'(vld_cnt), 256'(v0));
    e0 = err_cnt;
    send(HD, 32'h3412); send(BD, 32'h5); send(HD, 32'h0807);
    chk("rehead_err", 256'(error_pulse), 256'(1));
    send(BD, 32'hB0); send(TL, 32'hB1);
    pkt("rehead", 8'h07, 8'h08, 2, 32'hB0);
    chk("rehead_err_cnt", 256'(err_cnt), 256'(e0 + 1));
    tick();
    e0 = err_cnt; v0 = vld_cnt;
    send(HD, 32'h5655);
    for (int i = 0; i < 9; i++) begin
      send(BD, 32'hC0 + 32'(i));
      chk("ovf_err_timing", 256'(error_pulse), 256'(i == 8));
    end
    send(TL, 32'hCF);
    chk("ovf_no_valid", 256'(packet_out_valid), 256'(0));
    chk("ovf_ready", 256'(flit_in_ready), 256'(1));
    chk("ovf_err_cnt", 256'(err_cnt), 256'(e0 + 1));
    send(HD, 32'h7877); send(TL, 32'hD0);
    pkt("post_ovf", 8'h77, 8'h78, 1, 32'hD0);
    chk("ovf_no_pkt", 256'(vld_cnt), 256'(v0));
    tick();
    send(HD, 32'h2221); send(BD, 32'hE0); send(BD, 32'hE1);
    chk("pre_rst_len", 256'(packet_len), 256'(2));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_src", 256'(packet_src), 256'(0));
    chk("mid_rst_dst", 256'(packet_dst), 256'(0));
    chk("mid_rst_len", 256'(packet_len), 256'(0));
    chk("mid_rst_data", packet_data, 256'(0));
    chk("mid_rst_ready", 256'(flit_in_ready), 256'(0));
    chk("mid_rst_valid", 256'(packet_out_valid), 256'(0));
    #10 rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 256'(flit_in_ready), 256'(1));
    chk("post_rst_valid", 256'(packet_out_valid), 256'(0));
    send(HD, 32'h4443); send(BD, 32'hF0); send(TL, 32'hF1);
    pkt("post_rst", 8'h43, 8'h44, 2, 32'hF0);
    tick();
    chk("post_rst_done", 256'(packet_out_valid), 256'(0));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
